uart_rx_lvds_n_words: RTL and testbench

UART_RX_LVDS_N_WORDS -- requirements
Module: uart_rx_lvds_n_words

---
 rtl/uart_rx_lvds_n_words_if.sv | 26 ++
 rtl/uart_rx_lvds_n_words.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_lvds_n_words.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_lvds_n_words_if.sv
// Signal bundle for the multi-word LVDS UART receiver: serial input plus
// decoded frame, per-word strobes and link-health outputs.
interface uart_rx_lvds_n_words_if #(
   parameter int DATA_W = 16,
   parameter int CH_NUM = 10
);
   localparam int IDX_W = $clog2(CH_NUM + 1);

   logic                       rx_lvds;
   logic [CH_NUM*DATA_W-1:0]   data_out;
   logic                       frame_valid;
   logic                       word_valid;
   logic [IDX_W-1:0]           word_idx;
   logic [15:0]                errors_count;
   logic                       bad_connection;

   modport master (
      input  rx_lvds,
      output data_out, frame_valid, word_valid, word_idx, errors_count, bad_connection
   );

   modport slave (
      output rx_lvds,
      input  data_out, frame_valid, word_valid, word_idx, errors_count, bad_connection
   );
endinterface

// File: rtl/uart_rx_lvds_n_words.sv
// Serial word receiver: decodes checked, indexed words from an async line and
// assembles CH_NUM of them into a committed frame, tracking link health.
module uart_rx_lvds_n_words #(
   parameter int DATA_W       = 16,
   parameter int CH_NUM       = 10,
   parameter int CLK_PER_BIT  = 4,
   parameter int BAD_THR      = 100,
   parameter int TIMEOUT_CLKS = 65535
) (
   input  logic clk,
   input  logic rst,
   uart_rx_lvds_n_words_if.master bus
);
   localparam int IDX_W     = $clog2(CH_NUM + 1);
   localparam int WORD_BITS = DATA_W + 16 + IDX_W + 1;
   localparam int TMR_W     = $clog2(CLK_PER_BIT);
   localparam int CNT_W     = $clog2(WORD_BITS + 1);
   localparam int CON_W     = $clog2(BAD_THR + 1);
   localparam int IDL_W     = $clog2(TIMEOUT_CLKS + 1);
   localparam int SH_W      = CH_NUM * DATA_W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM);
   localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'(CLK_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] FULL_BIT = TMR_W'(CLK_PER_BIT - 1);
   localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(WORD_BITS);
   localparam logic [CON_W-1:0] CON_MAX  = CON_W'(BAD_THR);
   localparam logic [IDL_W-1:0] IDL_MAX  = IDL_W'(TIMEOUT_CLKS);

   typedef enum logic [1:0] {IDLE, START, SHIFT, CHECK} state_t;

   state_t              state_q, state_d;
   logic                rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_BITS:0]  sreg_q, sreg_d;
   logic [SH_W-1:0]     shadow_q, shadow_d, shadow_new;
   logic [CH_NUM-1:0]   mask_q, mask_d, mask_new;
   logic [SH_W-1:0]     data_out_q, data_out_d;
   logic                frame_valid_q, frame_valid_d, word_valid_q, word_valid_d;
   logic [IDX_W-1:0]    word_idx_q, word_idx_d;
   logic [15:0]         err_cnt_q, err_cnt_d;
   logic [CON_W-1:0]    consec_q, consec_d;
   logic [IDL_W-1:0]    idle_q, idle_d;
   logic                bad_q, bad_d;

   logic [DATA_W-1:0]   w_data;
   logic [15:0]         w_chk, exp_chk;
   logic [IDX_W-1:0]    w_idx;
   logic                w_par, w_stop, word_ok, good_word;
   logic [23:0]         prod;

   // Shift register holds data, check, index, parity, stop from LSB upwards.
   assign w_data = sreg_q[DATA_W-1:0];
   assign w_chk  = sreg_q[DATA_W +: 16];
   assign w_idx  = sreg_q[DATA_W+16 +: IDX_W];
   assign w_par  = sreg_q[WORD_BITS-1];
   assign w_stop = sreg_q[WORD_BITS];

   // Only the low 24 product bits reach the folded check value.
   assign prod    = 24'({w_idx, w_data}) * 24'd44111;
   assign exp_chk = prod[15:0] ^ prod[23:8];
   assign word_ok = (w_chk == exp_chk) && ((^{w_data, w_chk, w_idx}) == w_par) &&
                    w_stop && (w_idx != '0) && (w_idx <= LAST_IDX);
   assign good_word = (state_q == CHECK) && word_ok;

   always_comb begin
      shadow_new = shadow_q;
      mask_new   = mask_q;
      for (int unsigned k = 1; k <= CH_NUM; k++) begin
         if (w_idx == IDX_W'(k)) begin
            shadow_new[k*DATA_W-1 -: DATA_W] = w_data;
            mask_new[k-1] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rx_meta_d     = bus.rx_lvds;
      rx_sync_d     = rx_meta_q;
      rx_prev_d     = rx_sync_q;
      timer_d       = timer_q;
      cnt_d         = cnt_q;
      sreg_d        = sreg_q;
      shadow_d      = shadow_q;
      mask_d        = mask_q;
      data_out_d    = data_out_q;
      frame_valid_d = 1'b0;
      word_valid_d  = 1'b0;
      word_idx_d    = word_idx_q;
      err_cnt_d     = err_cnt_q;
      consec_d      = consec_q;
      idle_d        = (idle_q == IDL_MAX) ? idle_q : idle_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               state_d = START;
               timer_d = HALF_BIT;
            end
         end
         START: begin
            if (timer_q == '0) begin
               timer_d = FULL_BIT;
               cnt_d   = '0;
               state_d = rx_sync_q ? IDLE : SHIFT;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         SHIFT: begin
            if (timer_q == '0) begin
               sreg_d  = {rx_sync_q, sreg_q[WORD_BITS:1]};
               timer_d = FULL_BIT;
               if (cnt_q == LAST_SMP) state_d = CHECK;
               else                   cnt_d   = cnt_q + 1'b1;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (word_ok) begin
               shadow_d     = shadow_new;
               mask_d       = mask_new;
               word_valid_d = 1'b1;
               word_idx_d   = w_idx;
               consec_d     = '0;
               idle_d       = '0;
               if (w_idx == LAST_IDX) begin
                  mask_d = '0;
                  if (&mask_new) begin
                     data_out_d    = shadow_new;
                     frame_valid_d = 1'b1;
                  end
               end
            end else begin
               err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 1'b1;
               consec_d  = (consec_q == CON_MAX) ? consec_q : consec_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (good_word) bad_d = 1'b0;
      else           bad_d = bad_q | (consec_d == CON_MAX) | (idle_d == IDL_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         rx_prev_q     <= 1'b1;
         timer_q       <= '0;
         cnt_q         <= '0;
         sreg_q        <= '0;
         shadow_q      <= '0;
         mask_q        <= '0;
         data_out_q    <= '0;
         frame_valid_q <= 1'b0;
         word_valid_q  <= 1'b0;
         word_idx_q    <= '0;
         err_cnt_q     <= '0;
         consec_q      <= '0;
         idle_q        <= '0;
         bad_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         rx_meta_q     <= rx_meta_d;
         rx_sync_q     <= rx_sync_d;
         rx_prev_q     <= rx_prev_d;
         timer_q       <= timer_d;
         cnt_q         <= cnt_d;
         sreg_q        <= sreg_d;
         shadow_q      <= shadow_d;
         mask_q        <= mask_d;
         data_out_q    <= data_out_d;
         frame_valid_q <= frame_valid_d;
         word_valid_q  <= word_valid_d;
         word_idx_q    <= word_idx_d;
         err_cnt_q     <= err_cnt_d;
         consec_q      <= consec_d;
         idle_q        <= idle_d;
         bad_q         <= bad_d;
      end
   end

   assign bus.data_out       = data_out_q;
   assign bus.frame_valid    = frame_valid_q;
   assign bus.word_valid     = word_valid_q;
   assign bus.word_idx       = word_idx_q;
   assign bus.errors_count   = err_cnt_q;
   assign bus.bad_connection = bad_q;
endmodule

// File: tb/tb_uart_rx_lvds_n_words.sv
// Directed bench for uart_rx_lvds_n_words at default parameters: frame assembly,
// word rejection, partial frames, glitch/reset handling and link-fault flag.
module tb_uart_rx_lvds_n_words;
   localparam int DATA_W      = 16;
   localparam int CH_NUM      = 10;
   localparam int CLK_PER_BIT = 4;
   localparam int FB          = 39;   // start + 16 data + 16 check + 4 idx + parity + stop

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   wv_cnt = 0;
   int   fv_cnt = 0;
   logic [3:0] last_idx = '0;
   logic       bad_at_wv = 1'b1;

   uart_rx_lvds_n_words_if #(.DATA_W(DATA_W), .CH_NUM(CH_NUM)) bus();

   uart_rx_lvds_n_words #(
      .DATA_W(DATA_W), .CH_NUM(CH_NUM), .CLK_PER_BIT(CLK_PER_BIT),
      .BAD_THR(100), .TIMEOUT_CLKS(65535)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.word_valid) begin
         wv_cnt++;
         last_idx  = bus.word_idx;
         bad_at_wv = bus.bad_connection;
      end
      if (bus.frame_valid) fv_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] chk(input logic [3:0] i, input logic [15:0] d);
      logic [35:0] p, c;
      p = {16'b0, i, d} * 36'd44111;
      c = p ^ (p >> 8);
      return c[15:0];
   endfunction

   function automatic logic [FB-1:0] mk(input logic [15:0] d, input logic [15:0] c,
                                        input logic [3:0] i, input bit flip_par, input bit stop);
      logic par;
      par = (^{d, c, i}) ^ flip_par;
      return {stop, par, i, c, d, 1'b0};
   endfunction

   function automatic logic [15:0] slot(input logic [CH_NUM*DATA_W-1:0] v, input int k);
      return v[k*DATA_W-1 -: DATA_W];
   endfunction

   task automatic drive_bits(input logic [FB-1:0] f, input int n);
      for (int b = 0; b < n; b++) begin
         bus.rx_lvds = f[b];
         repeat (CLK_PER_BIT) @(negedge clk);
      end
   endtask

   task automatic send(input logic [FB-1:0] f);
      drive_bits(f, FB);
      bus.rx_lvds = 1'b1;
      repeat (2*CLK_PER_BIT) @(negedge clk);
   endtask

   task automatic send_good(input logic [3:0] i, input logic [15:0] d);
      send(mk(d, chk(i, d), i, 1'b0, 1'b1));
   endtask

   task automatic do_reset();
      bus.rx_lvds = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL rst_data_out got=%0h exp=0", bus.data_out); end
      checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL rst_frame_valid got=%b exp=0", bus.frame_valid); end
      checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL rst_word_valid got=%b exp=0", bus.word_valid); end
      checks++; if (bus.word_idx !== 4'd0) begin failures++; $display("FAIL rst_word_idx got=%0d exp=0", bus.word_idx); end
      checks++; if (bus.errors_count !== 16'd0) begin failures++; $display("FAIL rst_errors got=%0d exp=0", bus.errors_count); end
      checks++; if (bus.bad_connection !== 1'b0) begin failures++; $display("FAIL rst_bad_conn got=%b exp=0", bus.bad_connection); end
   endtask

   task automatic test_frame();
      int wv0, fv0;
      logic [15:0] d;
      wv0 = wv_cnt; fv0 = fv_cnt;
      for (int k = 1; k <= CH_NUM; k++) begin
         d = 16'(16'h1111 * k);
         send_good(4'(k), d);
      end
      checks++; if (wv_cnt - wv0 != 10) begin failures++; $display("FAIL frame_word_valid_count got=%0d exp=10", wv_cnt - wv0); end
      checks++; if (fv_cnt - fv0 != 1) begin failures++; $display("FAIL frame_valid_count got=%0d exp=1", fv_cnt - fv0); end
      checks++; if (slot(bus.data_out, 1) !== 16'h1111) begin failures++; $display("FAIL frame_slot1 got=%h exp=1111", slot(bus.data_out, 1)); end
      checks++; if (slot(bus.data_out, 7) !== 16'h7777) begin failures++; $display("FAIL frame_slot7 got=%h exp=7777", slot(bus.data_out, 7)); end
      checks++; if (slot(bus.data_out, 10) !== 16'hAAAA) begin failures++; $display("FAIL frame_slot10 got=%h exp=aaaa", slot(bus.data_out, 10)); end
      checks++; if (last_idx !== 4'd10) begin failures++; $display("FAIL frame_last_idx got=%0d exp=10", last_idx); end
      checks++; if (bus.errors_count !== 16'd0) begin failures++; $display("FAIL frame_errors got=%0d exp=0", bus.errors_count); end
   endtask

   task automatic test_check_value();
      int wv0;
      do_reset();
      wv0 = wv_cnt;
      send(mk(16'h0000, 16'h4F00, 4'd1, 1'b0, 1'b1));
      checks++; if (wv_cnt - wv0 != 1) begin failures++; $display("FAIL chk_good_accept got=%0d exp=1", wv_cnt - wv0); end
      checks++; if (last_idx !== 4'd1) begin failures++; $display("FAIL chk_good_idx got=%0d exp=1", last_idx); end
      send(mk(16'h0000, 16'h4F01, 4'd1, 1'b0, 1'b1));
      checks++; if (wv_cnt - wv0 != 1) begin failures++; $display("FAIL chk_bad_reject got=%0d exp=1", wv_cnt - wv0); end
      checks++; if (bus.errors_count !== 16'd1) begin failures++; $display("FAIL chk_bad_errors got=%0d exp=1", bus.errors_count); end
   endtask

   task automatic test_bad_words();
      int wv0;
      do_reset();
      wv0 = wv_cnt;
      send(mk(16'h1234, chk(4'd2, 16'h1234), 4'd2, 1'b1, 1'b1));
      checks++; if (bus.errors_count !== 16'd1) begin failures++; $display("FAIL bad_parity_errors got=%0d exp=1", bus.errors_count); end
      send(mk(16'h1234, chk(4'd2, 16'h1234), 4'd2, 1'b0, 1'b0));
      send(mk(16'h5678, chk(4'd0, 16'h5678), 4'd0, 1'b0, 1'b1));
      send(mk(16'h9ABC, chk(4'd11, 16'h9ABC), 4'd11, 1'b0, 1'b1));
      checks++; if (bus.errors_count !== 16'd4) begin failures++; $display("FAIL bad_total_errors got=%0d exp=4", bus.errors_count); end
      checks++; if (wv_cnt != wv0) begin failures++; $display("FAIL bad_word_valid got=%0d exp=0", wv_cnt - wv0); end
   endtask

   task automatic test_incomplete();
      int fv0;
      fv0 = fv_cnt;
      for (int k = 1; k <= CH_NUM; k++)
         if (k != 5) send_good(4'(k), 16'(16'h2000 + k));
      checks++; if (fv_cnt != fv0) begin failures++; $display("FAIL partial_frame_valid got=%0d exp=0", fv_cnt - fv0); end
      checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL partial_data_out got=%0h exp=0", bus.data_out); end
      send_good(4'd3, 16'h3333);
      for (int k = 1; k <= CH_NUM; k++) send_good(4'(k), 16'(16'h3000 + k));
      checks++; if (fv_cnt - fv0 != 1) begin failures++; $display("FAIL full_frame_valid got=%0d exp=1", fv_cnt - fv0); end
      checks++; if (slot(bus.data_out, 1) !== 16'h3001) begin failures++; $display("FAIL full_slot1 got=%h exp=3001", slot(bus.data_out, 1)); end
      checks++; if (slot(bus.data_out, 3) !== 16'h3003) begin failures++; $display("FAIL overwrite_slot3 got=%h exp=3003", slot(bus.data_out, 3)); end
      checks++; if (slot(bus.data_out, 5) !== 16'h3005) begin failures++; $display("FAIL full_slot5 got=%h exp=3005", slot(bus.data_out, 5)); end
      checks++; if (slot(bus.data_out, 10) !== 16'h300A) begin failures++; $display("FAIL full_slot10 got=%h exp=300a", slot(bus.data_out, 10)); end
      checks++; if (bus.errors_count !== 16'd4) begin failures++; $display("FAIL partial_no_error got=%0d exp=4", bus.errors_count); end
   endtask

   task automatic test_glitch_and_reset();
      int wv0;
      wv0 = wv_cnt;
      bus.rx_lvds = 1'b0;
      @(negedge clk);
      bus.rx_lvds = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (wv_cnt != wv0) begin failures++; $display("FAIL glitch_word_valid got=%0d exp=0", wv_cnt - wv0); end
      checks++; if (bus.errors_count !== 16'd4) begin failures++; $display("FAIL glitch_errors got=%0d exp=4", bus.errors_count); end
      drive_bits(mk(16'hBEEF, chk(4'd2, 16'hBEEF), 4'd2, 1'b0, 1'b1), 15);
      rst = 1'b1;
      bus.rx_lvds = 1'b1;
      @(negedge clk);
      checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL midrst_data_out got=%0h exp=0", bus.data_out); end
      checks++; if (bus.errors_count !== 16'd0) begin failures++; $display("FAIL midrst_errors got=%0d exp=0", bus.errors_count); end
      checks++; if (bus.word_idx !== 4'd0) begin failures++; $display("FAIL midrst_word_idx got=%0d exp=0", bus.word_idx); end
      checks++; if ({bus.frame_valid, bus.word_valid, bus.bad_connection} !== 3'b000) begin
         failures++; $display("FAIL midrst_flags got=%b exp=000", {bus.frame_valid, bus.word_valid, bus.bad_connection}); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      wv0 = wv_cnt;
      send_good(4'd1, 16'h0BEE);
      checks++; if (wv_cnt - wv0 != 1) begin failures++; $display("FAIL postrst_word_valid got=%0d exp=1", wv_cnt - wv0); end
      checks++; if (bus.errors_count !== 16'd0) begin failures++; $display("FAIL postrst_errors got=%0d exp=0", bus.errors_count); end
   endtask

   task automatic test_bad_connection();
      do_reset();
      for (int n = 0; n < 99; n++) send(mk(16'h00FF, chk(4'd2, 16'h00FF), 4'd2, 1'b1, 1'b1));
      checks++; if (bus.bad_connection !== 1'b0) begin failures++; $display("FAIL link_99_bad got=%b exp=0", bus.bad_connection); end
      send(mk(16'h00FF, chk(4'd2, 16'h00FF), 4'd2, 1'b1, 1'b1));
      checks++; if (bus.bad_connection !== 1'b1) begin failures++; $display("FAIL link_100_bad got=%b exp=1", bus.bad_connection); end
      checks++; if (bus.errors_count !== 16'd100) begin failures++; $display("FAIL link_errors got=%0d exp=100", bus.errors_count); end
      send_good(4'd4, 16'h4444);
      checks++; if (bad_at_wv !== 1'b0) begin failures++; $display("FAIL link_clear_with_word got=%b exp=0", bad_at_wv); end
      checks++; if (bus.bad_connection !== 1'b0) begin failures++; $display("FAIL link_clear got=%b exp=0", bus.bad_connection); end
      repeat (65400) @(negedge clk);
      checks++; if (bus.bad_connection !== 1'b0) begin failures++; $display("FAIL link_before_timeout got=%b exp=0", bus.bad_connection); end
      repeat (200) @(negedge clk);
      checks++; if (bus.bad_connection !== 1'b1) begin failures++; $display("FAIL link_timeout got=%b exp=1", bus.bad_connection); end
   endtask

   initial begin
      bus.rx_lvds = 1'b1;
      test_reset();
      test_frame();
      test_check_value();
      test_bad_words();
      test_incomplete();
      test_glitch_and_reset();
      test_bad_connection();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
